// File: rtl/register_file_gen2_if.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_gen2_if
//  Description : Bus bundle for register_file_gen2: write port, two read
//                ports, flag update/shadow controls and the scan handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface register_file_gen2_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
);
  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic [3:0]        flag_in;
  logic [3:0]        flag_upd;
  logic              flags_save;
  logic              flags_restore;
  logic [7:0]        flags;
  logic              scan_valid;
  logic              scan_ready;
  logic [ADDR_W:0]   scan_idx;
  logic [DATA_W-1:0] scan_data;

  // Driver side (CPU core / display consumer)
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output flag_in, flag_upd, flags_save, flags_restore, scan_ready,
    input  rd_data_a, rd_data_b, flags, scan_valid, scan_idx, scan_data
  );

  // Register file side
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  flag_in, flag_upd, flags_save, flags_restore, scan_ready,
    output rd_data_a, rd_data_b, flags, scan_valid, scan_idx, scan_data
  );
endinterface
`default_nettype wire

// File: rtl/register_file_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_gen2
//  Description : Parametrised register file with two combinational read
//                ports, optional write bypass, masked flags with a one-level
//                shadow, and a round-robin snapshot scan port.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_gen2 #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ZERO_R0  = 0,
  parameter int BYPASS   = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  register_file_gen2_if.slave bus
);
  localparam int              ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] FLAG_IDX = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SHOW = 1'b1
  } scan_state_e;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_ok;
  logic [3:0]        flags_q, flags_d;
  logic [3:0]        shadow_q, shadow_d;
  scan_state_e       state_q;
  logic              scan_valid_q;
  logic [ADDR_W:0]   scan_idx_q;
  logic [DATA_W-1:0] scan_data_q;
  logic [ADDR_W:0]   idx_adv;
  logic [ADDR_W:0]   idx_sel;
  logic [DATA_W-1:0] entry_val;

  // A write to register 0 is silently discarded when R0 is hardwired to zero.
  assign wr_ok = bus.wr_en && !((ZERO_R0 != 0) && (bus.wr_addr == '0));

  // Post-edge view of the array: serves both the bypass path and scan capture.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (wr_ok && (bus.wr_addr == ADDR_W'(i))) ? bus.wr_data : regs_q[i];
    end
  end

  // Register array storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      assign bus.rd_data_a = regs_d[bus.rd_addr_a];
      assign bus.rd_data_b = regs_d[bus.rd_addr_b];
    end else begin : g_no_bypass
      assign bus.rd_data_a = regs_q[bus.rd_addr_a];
      assign bus.rd_data_b = regs_q[bus.rd_addr_b];
    end
  endgenerate

  // Restore wins over masked update; save always captures the pre-edge flags,
  // so save+restore together swaps flags and shadow.
  always_comb begin
    flags_d  = bus.flags_restore ? shadow_q
                                 : ((flags_q & ~bus.flag_upd) | (bus.flag_in & bus.flag_upd));
    shadow_d = bus.flags_save ? flags_q : shadow_q;
  end

  // Flags and shadow storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q  <= '0;
      shadow_q <= '0;
    end else begin
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.flags = {4'b0000, flags_q};

  // Next scan entry and its post-edge value (the flags entry follows the regs).
  always_comb begin
    idx_adv   = (scan_idx_q == FLAG_IDX) ? '0 : scan_idx_q + (ADDR_W+1)'(1);
    idx_sel   = (state_q == S_IDLE) ? '0 : idx_adv;
    entry_val = DATA_W'({4'b0000, flags_d});
    if (idx_sel != FLAG_IDX) entry_val = regs_d[idx_sel[ADDR_W-1:0]];
  end

  // Scan FSM: IDLE presents entry 0, SHOW advances on each accepted entry and
  // otherwise holds its snapshot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      scan_valid_q <= 1'b0;
      scan_idx_q   <= '0;
      scan_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q      <= S_SHOW;
          scan_valid_q <= 1'b1;
          scan_idx_q   <= '0;
          scan_data_q  <= entry_val;
        end
        S_SHOW: begin
          if (bus.scan_ready) begin
            scan_idx_q  <= idx_adv;
            scan_data_q <= entry_val;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          scan_valid_q <= 1'b0;
          scan_idx_q   <= '0;
          scan_data_q  <= '0;
        end
      endcase
    end
  end

  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_idx   = scan_idx_q;
  assign bus.scan_data  = scan_data_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_gen2
//  Description : Self-checking bench for register_file_gen2 (default build
//                plus a ZERO_R0=1 / BYPASS=0 build sharing the stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_gen2;
  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic [7:0] data;
  } scan_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  register_file_gen2_if #(.DATA_W(8), .NUM_REGS(4)) ifm ();
  register_file_gen2_if #(.DATA_W(8), .NUM_REGS(4)) ifz ();

  register_file_gen2 #(.DATA_W(8), .NUM_REGS(4), .ZERO_R0(0), .BYPASS(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifm.slave));
  register_file_gen2 #(.DATA_W(8), .NUM_REGS(4), .ZERO_R0(1), .BYPASS(0)) dut_z (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifz.slave));

  assign ifz.wr_en         = ifm.wr_en;
  assign ifz.wr_addr       = ifm.wr_addr;
  assign ifz.wr_data       = ifm.wr_data;
  assign ifz.rd_addr_a     = ifm.rd_addr_a;
  assign ifz.rd_addr_b     = ifm.rd_addr_b;
  assign ifz.flag_in       = ifm.flag_in;
  assign ifz.flag_upd      = ifm.flag_upd;
  assign ifz.flags_save    = ifm.flags_save;
  assign ifz.flags_restore = ifm.flags_restore;
  assign ifz.scan_ready    = ifm.scan_ready;

  always #5 clk = ~clk;

  // Reference state
  logic [7:0] m_regs [4];
  logic [7:0] m_regz [4];
  logic [3:0] m_fl, m_sh;
  logic       m_valid;
  logic [2:0] m_idx;
  logic [7:0] m_data;
  scan_t      exp_q [$];

  task automatic chk_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_regs[i] = 8'h00;
      m_regz[i] = 8'h00;
    end
    m_fl = 4'h0; m_sh = 4'h0;
    m_valid = 1'b0; m_idx = 3'd0; m_data = 8'h00;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    ifm.wr_en = 1'b0; ifm.flag_upd = 4'h0;
    ifm.flags_save = 1'b0; ifm.flags_restore = 1'b0;
  endtask

  // One clock: predict post-edge state, push expected scan entry, then pop
  // and compare once the DUT has taken the edge.
  task automatic tick();
    logic [7:0] nr [4];
    logic [7:0] nz [4];
    logic [3:0] nf, ns;
    logic [2:0] ni;
    scan_t      e, got_e;
    for (int i = 0; i < 4; i++) begin
      nr[i] = m_regs[i];
      nz[i] = m_regz[i];
    end
    if (ifm.wr_en) begin
      nr[ifm.wr_addr] = ifm.wr_data;
      if (ifm.wr_addr != 2'd0) nz[ifm.wr_addr] = ifm.wr_data;
    end
    nf = ifm.flags_restore ? m_sh : ((m_fl & ~ifm.flag_upd) | (ifm.flag_in & ifm.flag_upd));
    ns = ifm.flags_save ? m_fl : m_sh;
    e.v = 1'b1;
    if (!m_valid) begin
      e.idx = 3'd0; e.data = nr[0];
    end else if (ifm.scan_ready) begin
      ni = (m_idx == 3'd4) ? 3'd0 : m_idx + 3'd1;
      e.idx  = ni;
      e.data = (ni == 3'd4) ? {4'h0, nf} : nr[ni[1:0]];
    end else begin
      e.idx = m_idx; e.data = m_data;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_regs[i] = nr[i];
      m_regz[i] = nz[i];
    end
    m_fl = nf; m_sh = ns;
    got_e = exp_q.pop_front();
    m_valid = got_e.v; m_idx = got_e.idx; m_data = got_e.data;
    chk_value("scan_valid", ifm.scan_valid, got_e.v);
    chk_value("scan_idx", ifm.scan_idx, got_e.idx);
    chk_value("scan_data", ifm.scan_data, got_e.data);
    chk_value("flags", ifm.flags, {4'h0, m_fl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifm.rd_addr_a = 2'd0; ifm.rd_addr_b = 2'd0;
    ifm.wr_addr = 2'd0; ifm.wr_data = 8'h00;
    ifm.flag_in = 4'h0; ifm.scan_ready = 1'b0;
    idle_inputs();
    model_reset();

    // Reset values, visible without any clock edge
    #1;
    chk_value("rst_rd_a", ifm.rd_data_a, 8'h00);
    chk_value("rst_flags", ifm.flags, 8'h00);
    chk_value("rst_scan_valid", ifm.scan_valid, 1'b0);
    chk_value("rst_scan_idx", ifm.scan_idx, 3'd0);
    chk_value("rst_scan_data", ifm.scan_data, 8'h00);

    @(negedge clk) rst_n = 1'b1;
    tick();  // IDLE -> SHOW, entry 0 presented

    // Fill registers, then read back on both ports
    for (int i = 0; i < 4; i++) begin
      ifm.wr_en = 1'b1; ifm.wr_addr = 2'(i); ifm.wr_data = 8'(8'h11 * (i + 1));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      ifm.rd_addr_a = 2'(i); ifm.rd_addr_b = 2'(3 - i);
      #1;
      chk_value("rd_a", ifm.rd_data_a, m_regs[i]);
      chk_value("rd_b", ifm.rd_data_b, m_regs[3 - i]);
      chk_value("z_rd_a", ifz.rd_data_a, m_regz[i]);
    end
    ifm.rd_addr_b = 2'd1; #1;
    chk_value("same_reg_b", ifm.rd_data_b, 8'h22);
    ifm.rd_addr_a = 2'd1; #1;
    chk_value("same_reg_a", ifm.rd_data_a, 8'h22);

    // Bypass versus registered read in the same cycle as a write
    ifm.wr_en = 1'b1; ifm.wr_addr = 2'd2; ifm.wr_data = 8'hA5; ifm.rd_addr_a = 2'd2;
    #1;
    chk_value("bypass_on", ifm.rd_data_a, 8'hA5);
    chk_value("bypass_off", ifz.rd_data_a, 8'h33);
    tick();
    idle_inputs();
    #1;
    chk_value("after_wr", ifz.rd_data_a, 8'hA5);

    // Masked update, save, update, restore
    ifm.flag_in = 4'b1111; ifm.flag_upd = 4'b0101; tick();
    chk_value("flag_mask", ifm.flags, 8'h05);
    idle_inputs(); ifm.flags_save = 1'b1; tick();
    idle_inputs(); ifm.flag_in = 4'b1010; ifm.flag_upd = 4'b1111; tick();
    chk_value("flag_upd", ifm.flags, 8'h0A);
    idle_inputs(); ifm.flags_restore = 1'b1; ifm.flag_upd = 4'b1111; tick();
    chk_value("flag_restore", ifm.flags, 8'h05);

    // Save + restore together swaps flags and shadow
    idle_inputs(); ifm.flag_in = 4'hC; ifm.flag_upd = 4'hF; tick();
    idle_inputs(); ifm.flags_save = 1'b1; tick();
    idle_inputs(); ifm.flag_in = 4'h3; ifm.flag_upd = 4'hF; tick();
    idle_inputs(); ifm.flags_save = 1'b1; ifm.flags_restore = 1'b1; tick();
    chk_value("swap_flags", ifm.flags, 8'h0C);
    idle_inputs(); ifm.flags_restore = 1'b1; tick();
    chk_value("swap_shadow", ifm.flags, 8'h03);
    idle_inputs();

    // Continuous scan through all entries including the flags slot
    ifm.scan_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();

    // Scan with random same-edge writes and flag updates
    for (int k = 0; k < 12; k++) begin
      ifm.wr_en = 1'($urandom_range(0, 1)); ifm.wr_addr = 2'($urandom_range(0, 3));
      ifm.wr_data = 8'($urandom); ifm.flag_in = 4'($urandom); ifm.flag_upd = 4'($urandom);
      ifm.scan_ready = 1'($urandom_range(0, 1));
      tick();
    end
    idle_inputs();

    // Reach index 1, then stall and overwrite the displayed register
    ifm.scan_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (m_idx == 3'd1) break;
      tick();
    end
    chk_value("reach_idx1", m_idx, 3'd1);
    ifm.scan_ready = 1'b0;
    ifm.wr_en = 1'b1; ifm.wr_addr = 2'd1; ifm.wr_data = 8'hFF;
    tick();
    idle_inputs();
    tick();
    chk_value("hold_snapshot", ifm.scan_data, m_data);

    // Asynchronous reset mid-hold
    #2 rst_n = 1'b0;
    #1;
    chk_value("mid_rst_valid", ifm.scan_valid, 1'b0);
    chk_value("mid_rst_idx", ifm.scan_idx, 3'd0);
    chk_value("mid_rst_data", ifm.scan_data, 8'h00);
    chk_value("mid_rst_flags", ifm.flags, 8'h00);
    chk_value("mid_rst_rd_a", ifm.rd_data_a, 8'h00);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    ifm.scan_ready = 1'b1;
    tick();
    chk_value("post_rst_valid", ifm.scan_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
